// File: rtl/seq_mult8_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier controller.
// The optional macro SEQ_MULT8_APPROX_LL_SKIP_EN is consumed by seq_mult8_ctrl.
package seq_mult8_pkg;
  localparam int OP_W    = 8;
  localparam int SLICE_W = 4;
  localparam int RES_W   = 16;

  localparam logic [3:0] SHIFT_LL  = 4'd0;
  localparam logic [3:0] SHIFT_MID = 4'd4;
  localparam logic [3:0] SHIFT_HH  = 4'd8;

  typedef enum logic [2:0] {
    IDLE,
    PP_LL,
    PP_LH,
    PP_HL,
    PP_HH,
    DONE
  } state_t;

  function automatic logic [RES_W-1:0] align_pp(input logic [2*SLICE_W-1:0] pp,
                                                 input logic [3:0] shift);
    return RES_W'(pp) << shift;
  endfunction
endpackage

// File: rtl/four_bit_dadda_multiplier.sv
// Combinational unsigned 4x4 multiplier; the gated partial-product rows are
// summed here and the tool builds the reduction tree.
module four_bit_dadda_multiplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [7:0] row [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    assign row[gi] = {4'b0000, a & {4{b[gi]}}} << gi;
  end

  assign p = row[0] + row[1] + row[2] + row[3];
endmodule

// File: rtl/seq_mult8_ctrl.sv
// Sequencer for an unsigned 8x8 product using one shared 4x4 multiplier.
// Define SEQ_MULT8_APPROX_LL_SKIP_EN to drop the low-slice product (3-cycle approx mode).
module seq_mult8_ctrl
  import seq_mult8_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic             ready,
  output logic             valid_out,
  output logic [RES_W-1:0] product
);
`ifdef SEQ_MULT8_APPROX_LL_SKIP_EN
  localparam state_t FIRST_PP = PP_LH;
`else
  localparam state_t FIRST_PP = PP_LL;
`endif

  state_t             state_reg;
  logic [OP_W-1:0]    a_reg;
  logic [OP_W-1:0]    b_reg;
  logic [RES_W-1:0]   acc_reg;
  logic [SLICE_W-1:0] mul_a;
  logic [SLICE_W-1:0] mul_b;
  logic [3:0]         shift_amt;
  logic [2*SLICE_W-1:0] mul_p;
  logic [RES_W-1:0]   acc_next;

  four_bit_dadda_multiplier u_mult (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  // Slice selection follows the state; idle states keep the multiplier quiet.
  always_comb begin
    mul_a     = '0;
    mul_b     = '0;
    shift_amt = SHIFT_LL;
    case (state_reg)
      PP_LL: begin
        mul_a     = a_reg[SLICE_W-1:0];
        mul_b     = b_reg[SLICE_W-1:0];
        shift_amt = SHIFT_LL;
      end
      PP_LH: begin
        mul_a     = a_reg[SLICE_W-1:0];
        mul_b     = b_reg[OP_W-1:SLICE_W];
        shift_amt = SHIFT_MID;
      end
      PP_HL: begin
        mul_a     = a_reg[OP_W-1:SLICE_W];
        mul_b     = b_reg[SLICE_W-1:0];
        shift_amt = SHIFT_MID;
      end
      PP_HH: begin
        mul_a     = a_reg[OP_W-1:SLICE_W];
        mul_b     = b_reg[OP_W-1:SLICE_W];
        shift_amt = SHIFT_HH;
      end
      default: ;
    endcase
  end

  assign acc_next = acc_reg + align_pp(mul_p, shift_amt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      product   <= '0;
      valid_out <= 1'b0;
      ready     <= 1'b1;
    end else begin
      valid_out <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            acc_reg   <= '0;
            state_reg <= FIRST_PP;
            ready     <= 1'b0;
          end else begin
            state_reg <= IDLE;
            ready     <= 1'b1;
          end
        end
        PP_LL: begin
          acc_reg   <= acc_next;
          state_reg <= PP_LH;
        end
        PP_LH: begin
          acc_reg   <= acc_next;
          state_reg <= PP_HL;
        end
        PP_HL: begin
          acc_reg   <= acc_next;
          state_reg <= PP_HH;
        end
        PP_HH: begin
          // Only the completed sum is ever published on product.
          acc_reg   <= acc_next;
          product   <= acc_next;
          valid_out <= 1'b1;
          ready     <= 1'b1;
          state_reg <= DONE;
        end
        default: begin
          state_reg <= IDLE;
          ready     <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mult8_ctrl.sv
// Directed-vector bench for seq_mult8_ctrl; expected products are hand-computed
// for both the exact build and the SEQ_MULT8_APPROX_LL_SKIP_EN build.
module tb_seq_mult8_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        ready;
  logic        valid_out;
  logic [15:0] product;

  int checks   = 0;
  int failures = 0;

`ifdef SEQ_MULT8_APPROX_LL_SKIP_EN
  localparam int          LAT      = 3;
  localparam int          HL_EDGES = 1;
  localparam logic [15:0] EXP_FFFF = 16'hFD20;
  localparam logic [15:0] EXP_1234 = 16'h03A0;
  localparam logic [15:0] EXP_0FF0 = 16'h0E10;
  localparam logic [15:0] EXP_3X5  = 16'd0;
  localparam logic [15:0] EXP_10X20 = 16'd160;
  localparam logic [15:0] EXP_7X6  = 16'd0;
`else
  localparam int          LAT      = 4;
  localparam int          HL_EDGES = 2;
  localparam logic [15:0] EXP_FFFF = 16'hFE01;
  localparam logic [15:0] EXP_1234 = 16'h03A8;
  localparam logic [15:0] EXP_0FF0 = 16'h0E10;
  localparam logic [15:0] EXP_3X5  = 16'd15;
  localparam logic [15:0] EXP_10X20 = 16'd200;
  localparam logic [15:0] EXP_7X6  = 16'd42;
`endif
  localparam logic [15:0] EXP_80X2 = 16'd256;

  always #5 clk = ~clk;

  seq_mult8_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .valid_out (valid_out),
    .product   (product)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end else begin
      $display("ok   %s = %0d (0x%0h)", tag, got, got);
    end
  endtask

  // Called #1 after an edge; returns edges elapsed until valid_out is seen (20 = timeout).
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!valid_out && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] exp);
    int cyc;
    check({tag, "_ready_before"}, 32'(ready), 32'd1);
    start = 1'b1; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = ~av; b = ~bv;
    check({tag, "_busy"}, 32'(ready), 32'd0);
    wait_valid(cyc);
    check({tag, "_latency"}, 32'(cyc), 32'(LAT));
    check({tag, "_product"}, 32'(product), 32'(exp));
    @(posedge clk); #1;
    check({tag, "_pulse_end"}, 32'(valid_out), 32'd0);
    check({tag, "_hold"}, 32'(product), 32'(exp));
    check({tag, "_ready_after"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int pulses;
    int cyc;
    int gap;
    logic [15:0] seen;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_product", 32'(product), 32'd0);
    check("reset_valid", 32'(valid_out), 32'd0);
    check("reset_ready", 32'(ready), 32'd1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (valid_out) pulses++;
    end
    check("idle_no_valid", 32'(pulses), 32'd0);

    run_op("ff_x_ff", 8'hFF, 8'hFF, EXP_FFFF);
    run_op("12_x_34", 8'h12, 8'h34, EXP_1234);
    run_op("00_x_ab", 8'h00, 8'hAB, 16'h0000);
    run_op("0f_x_f0", 8'h0F, 8'hF0, EXP_0FF0);

    // Busy: a second start and operand changes mid-operation must not disturb the result.
    start = 1'b1; a = 8'd3; b = 8'd5;
    @(posedge clk); #1;
    a = 8'd9; b = 8'd9;
    @(posedge clk); #1;
    start = 1'b0; a = 8'hEE; b = 8'h77;
    pulses = 0; seen = '0;
    for (int i = 0; i < 10; i++) begin
      if (valid_out) begin
        pulses++;
        seen = product;
      end
      @(posedge clk); #1;
    end
    check("busy_pulses", 32'(pulses), 32'd1);
    check("busy_product", 32'(seen), 32'(EXP_3X5));
    check("busy_ready_after", 32'(ready), 32'd1);

    // Reset while in PP_HL.
    start = 1'b1; a = 8'h55; b = 8'h66;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (HL_EDGES) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_product", 32'(product), 32'd0);
    check("midrst_valid", 32'(valid_out), 32'd0);
    check("midrst_ready", 32'(ready), 32'd1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (valid_out) pulses++;
    end
    check("midrst_no_valid", 32'(pulses), 32'd0);
    run_op("10_x_20", 8'd10, 8'd20, EXP_10X20);

    // Back-to-back: start held; the DONE cycle itself accepts the next pair,
    // so the pulses are one accept edge plus LAT edges apart.
    start = 1'b1; a = 8'd7; b = 8'd6;
    @(posedge clk); #1;
    wait_valid(cyc);
    check("b2b_first_latency", 32'(cyc), 32'(LAT));
    check("b2b_first_product", 32'(product), 32'(EXP_7X6));
    a = 8'h80; b = 8'd2;
    @(posedge clk); #1;
    check("b2b_pulse_end", 32'(valid_out), 32'd0);
    wait_valid(cyc);
    gap = cyc + 1;
    check("b2b_gap", 32'(gap), 32'(LAT + 1));
    check("b2b_second_product", 32'(product), 32'(EXP_80X2));
    start = 1'b0;
    @(posedge clk); #1;
    check("b2b_final_valid", 32'(valid_out), 32'd0);
    check("b2b_final_ready", 32'(ready), 32'd1);
    check("b2b_final_hold", 32'(product), 32'(EXP_80X2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
